// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the decode-stage issue scoreboard.
package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } sb_state_t;

  localparam int REG_COUNT = 32;
  localparam int REG_ID_W  = 5;

  // One-hot select of a register; x0 is never tracked, so its bit is never set.
  function automatic logic [REG_COUNT-1:0] id_decode(input logic en,
                                                     input logic [REG_ID_W-1:0] id);
    logic [REG_COUNT-1:0] sel;
    sel = '0;
    if (en && id != '0) sel[id] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/issue_scoreboard_pending_counter.sv
// Per-register count of in-flight writes: one increment and two independent
// decrements per cycle, net sum applied, clamped at zero.
module pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero
);

  logic [CNT_W:0]   up;
  logic [1:0]       down;
  logic [CNT_W-1:0] cnt_next;

  // NOTE: every intermediate gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    up       = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
    down     = {1'b0, dec_wb} + {1'b0, dec_kill};
    cnt_next = (up < (CNT_W+1)'(down)) ? '0 : CNT_W'(up - (CNT_W+1)'(down));
  end

  // NOTE: each counter is reset individually; a stale count would raise phantom hazards after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_next;
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue control: RAW/saturation stalls, ID/EX bubbles and a branch-flush window.
// Optional SCOREBOARD_PERF_EN adds stall_cycles and flush_count performance counters.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_writes_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_id,
  input  logic        kill_en,
  input  logic [4:0]  kill_id,
  input  logic        flush_req,
  output logic        stall,
  output logic        bubble,
  output logic        issue,
  output logic        flush_active,
  output logic [31:0] busy_mask
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  sb_state_t            state, state_next;
  logic [FC_W-1:0]      flush_cnt, flush_cnt_next;
  logic [CNT_W-1:0]     pending [REG_COUNT];
  logic [REG_COUNT-1:0] inc_vec, wb_vec, kill_vec, nonzero;
  logic                 rs1_hazard, rs2_hazard, rd_hazard, hazard;

  assign inc_vec  = id_decode(issue & id_writes_rd, id_rd);
  assign wb_vec   = id_decode(wb_en, wb_id);
  assign kill_vec = id_decode(kill_en, kill_id);

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
    pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (inc_vec[r]),
      .dec_wb   (wb_vec[r]),
      .dec_kill (kill_vec[r]),
      .cnt      (pending[r]),
      .nonzero  (nonzero[r])
    );
  end

  assign busy_mask = nonzero;

  // A source whose last pending write lands this cycle is read after the register file write.
  assign rs1_hazard = id_uses_rs1 && pending[id_rs1] != '0 &&
                      !(pending[id_rs1] == CNT_W'(1) && wb_en && wb_id == id_rs1);
  assign rs2_hazard = id_uses_rs2 && pending[id_rs2] != '0 &&
                      !(pending[id_rs2] == CNT_W'(1) && wb_en && wb_id == id_rs2);
  assign rd_hazard  = id_writes_rd && id_rd != '0 && pending[id_rd] == CNT_MAX;
  assign hazard     = id_valid && (rs1_hazard || rs2_hazard || rd_hazard);

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    stall          = 1'b0;
    bubble         = 1'b1;
    issue          = 1'b0;
    flush_active   = 1'b0;
    unique case (state)
      RUN, STALL: begin
        if (hazard) begin
          stall      = 1'b1;
          state_next = STALL;
        end else begin
          issue      = id_valid;
          bubble     = ~id_valid;
          state_next = RUN;
        end
      end
      FLUSH: begin
        flush_active = 1'b1;
        if (flush_cnt == '0) state_next = RUN;
        else                 flush_cnt_next = flush_cnt - 1'b1;
      end
      default: state_next = RUN;
    endcase
    // The redirect owns the PC on a flush, so decode is neither held nor issued.
    if (flush_req) begin
      state_next     = FLUSH;
      flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
      stall          = 1'b0;
      issue          = 1'b0;
      bubble         = 1'b1;
    end
    if (!reset_n) begin
      stall        = 1'b0;
      issue        = 1'b0;
      bubble       = 1'b1;
      flush_active = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall)     stall_cycles <= stall_cycles + 32'd1;
      if (flush_req) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized
// traffic compared every cycle against a counting model of in-flight writes.
module tb_issue_scoreboard;

  localparam int CNT_W        = 2;
  localparam int FLUSH_CYCLES = 1;
  localparam int MAXP         = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic        wb_en, kill_en, flush_req;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_id, kill_id;
  logic        stall, bubble, issue, flush_active;
  logic [31:0] busy_mask;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding writes per register and remaining flush cycles.
  int pend [32];
  int flush_left;
  bit e_stall, e_bubble, e_issue, e_fa;
  int m_stall_cycles, m_flush_count;

  always #5 clk = ~clk;

  issue_scoreboard #(.CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_writes_rd (id_writes_rd),
    .wb_en        (wb_en),
    .wb_id        (wb_id),
    .kill_en      (kill_en),
    .kill_id      (kill_id),
    .flush_req    (flush_req),
    .stall        (stall),
    .bubble       (bubble),
    .issue        (issue),
    .flush_active (flush_active),
    .busy_mask    (busy_mask)
`ifdef SCOREBOARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    flush_left     = 0;
    m_stall_cycles = 0;
    m_flush_count  = 0;
  endtask

  function automatic bit src_blocked(input bit uses, input int rs);
    return uses && pend[rs] > 0 && !(pend[rs] == 1 && wb_en && int'(wb_id) == rs);
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = (pend[r] != 0);
    return m;
  endfunction

  task automatic model_outputs();
    bit hz;
    hz = id_valid && (src_blocked(id_uses_rs1, int'(id_rs1)) ||
                      src_blocked(id_uses_rs2, int'(id_rs2)) ||
                      (id_writes_rd && id_rd != 0 && pend[id_rd] == MAXP));
    e_fa     = (flush_left > 0);
    e_stall  = 0;
    e_issue  = 0;
    e_bubble = 1;
    if (!flush_req && flush_left == 0) begin
      if (hz) e_stall = 1;
      else begin
        e_issue  = id_valid;
        e_bubble = !id_valid;
      end
    end
  endtask

  task automatic drive(input bit v, input bit u1, input int rs1, input bit u2, input int rs2,
                       input bit wr, input int rd, input bit wbe = 0, input int wbid = 0,
                       input bit ke = 0, input int kid = 0, input bit fr = 0);
    id_valid     = v;
    id_uses_rs1  = u1;
    id_rs1       = 5'(rs1);
    id_uses_rs2  = u2;
    id_rs2       = 5'(rs2);
    id_writes_rd = wr;
    id_rd        = 5'(rd);
    wb_en        = wbe;
    wb_id        = 5'(wbid);
    kill_en      = ke;
    kill_id      = 5'(kid);
    flush_req    = fr;
  endtask

  // Let combinational outputs settle and compare them against the model.
  task automatic settle();
    #1;
    model_outputs();
    check("stall", stall, e_stall);
    check("bubble", bubble, e_bubble);
    check("issue", issue, e_issue);
    check("flush_active", flush_active, e_fa);
    check("busy_mask", busy_mask, exp_busy());
`ifdef SCOREBOARD_PERF_EN
    check("stall_cycles", stall_cycles, m_stall_cycles);
    check("flush_count", flush_count, m_flush_count);
`endif
  endtask

  task automatic tick();
    int d;
    @(posedge clk);
    #1;
    for (int r = 1; r < 32; r++) begin
      d = 0;
      if (e_issue && id_writes_rd && int'(id_rd) == r) d++;
      if (wb_en && int'(wb_id) == r) d--;
      if (kill_en && int'(kill_id) == r) d--;
      pend[r] = (pend[r] + d < 0) ? 0 : pend[r] + d;
    end
    if (e_stall)   m_stall_cycles++;
    if (flush_req) m_flush_count++;
    if (flush_req)           flush_left = FLUSH_CYCLES;
    else if (flush_left > 0) flush_left--;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(1, 1, 3, 0, 0, 1, 4);
    model_reset();
    #2;
    check("rst_stall", stall, 0);
    check("rst_bubble", bubble, 1);
    check("rst_issue", issue, 0);
    check("rst_flush_active", flush_active, 0);
    check("rst_busy_mask", busy_mask, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // RAW on x5, released by its write-back in the same cycle.
    drive(1, 0, 0, 0, 0, 1, 5); step();
    drive(1, 1, 5, 0, 0, 0, 0); settle(); check("x5_raw_stall", stall, 1); tick();
    settle(); check("x5_raw_stall2", stall, 1); tick();
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5); settle();
    check("x5_bypass_issue", issue, 1);
    check("x5_bypass_nostall", stall, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); settle(); check("x5_busy_clear", busy_mask[5], 0); tick();

    // Saturation of x7 at three in-flight writes.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 7); settle(); check("x7_fill_issue", issue, 1); tick();
    end
    settle(); check("x7_sat_stall", stall, 1); tick();
    drive(1, 0, 0, 0, 0, 1, 7, 1, 7); settle(); check("x7_sat_wb_stall", stall, 1); tick();
    drive(1, 0, 0, 0, 0, 1, 7); settle(); check("x7_fourth_issue", issue, 1); tick();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 7); step(); end

    // Flush taken while stalled.
    drive(1, 0, 0, 0, 0, 1, 8); step();
    drive(1, 1, 8, 0, 0, 0, 0); settle(); check("fl_pre_stall", stall, 1); tick();
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1); settle();
    check("fl_req_issue", issue, 0);
    check("fl_req_bubble", bubble, 1);
    tick();
    drive(1, 1, 8, 0, 0, 0, 0); settle();
    check("fl_active", flush_active, 1);
    check("fl_stall", stall, 0);
    check("fl_bubble", bubble, 1);
    check("fl_issue", issue, 0);
    tick();
    settle(); check("fl_done", flush_active, 0); check("fl_run_stall", stall, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 8); step();

    // Kill of the only pending write to x9.
    drive(1, 0, 0, 0, 0, 1, 9); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step();
    drive(1, 1, 9, 0, 0, 0, 0); settle();
    check("kill_busy9", busy_mask[9], 0);
    check("kill_reader_issue", issue, 1);
    check("kill_reader_nostall", stall, 0);
    tick();

    // x0 is never tracked.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 1, 0, 1, 0); settle();
      check("x0_nostall", stall, 0);
      check("x0_busy", busy_mask, 0);
      tick();
    end

    // Randomized traffic over a small register window to provoke hazards and saturation.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 1) != 0, $urandom_range(0, 7),
            $urandom_range(0, 1) != 0, $urandom_range(0, 7),
            $urandom_range(0, 1) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            $urandom_range(0, 15) == 0, $urandom_range(0, 7),
            $urandom_range(0, 24) == 0);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, (i % 7) + 1);
      step();
    end

    // Asynchronous reset in the middle of a stall.
    drive(1, 0, 0, 0, 0, 1, 5);  step();
    drive(1, 0, 0, 0, 0, 1, 10); step();
    drive(1, 1, 5, 0, 0, 0, 0);  step();
    settle();
    check("mid_busy_mask", busy_mask, 32'h0000_0420);
    check("mid_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy", busy_mask, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_bubble", bubble, 1);
    check("mid_rst_issue", issue, 0);
    check("mid_rst_flush_active", flush_active, 0);
    #1;
    reset_n = 1'b1;
    settle(); check("post_rst_issue", issue, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
